// File: rtl/axi_lite_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_regfile_pkg
// Description : AXI4 protection/response types and response encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_regfile_pkg;

    typedef logic [2:0] prot_t;
    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    function automatic resp_t resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_regfile_if
// Description : AXI4-Lite bus bundle with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_regfile_if
    import axi_lite_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int c_strb_width = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0]   awaddr;
    prot_t                   awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [c_strb_width-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    resp_t                   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    prot_t                   arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    resp_t                   rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface
`default_nettype wire

// File: rtl/axi_lite_regfile_strb_reg.sv
`default_nettype none
// ============================================================================
// Module      : axi_strb_reg
// Description : One data word with synchronous reset and byte-strobe writes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_strb_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_we,
    input  wire logic [DATA_WIDTH/8-1:0] i_strb,
    input  wire logic [DATA_WIDTH-1:0]   i_wdata,
    output logic      [DATA_WIDTH-1:0]   o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            for (int j = 0; j < DATA_WIDTH / 8; j++) begin
                if (i_strb[j]) r_q[j*8 +: 8] <= i_wdata[j*8 +: 8];
            end
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_regfile
// Description : AXI4-Lite slave exposing NUM_REGS strobe-writable registers.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regfile
    import axi_lite_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  wire logic                         aclk,
    input  wire logic                         areset,
    axi_lite_regfile_if.slave                 s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0]    regs_o,
    output logic [NUM_REGS-1:0]               wr_pulse_o
);

    localparam int c_strb_width = DATA_WIDTH / 8;
    localparam int c_word_lsb   = $clog2(c_strb_width);

    logic                    r_awready, r_wready, r_arready;
    logic                    r_aw_full, r_w_full;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_strb_width-1:0] r_wstrb;
    logic                    r_bvalid;
    resp_t                   r_bresp;
    logic                    r_rvalid;
    resp_t                   r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [NUM_REGS-1:0]     r_wr_pulse;

    logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic                    w_aw_full_nxt, w_w_full_nxt, w_rvalid_nxt;
    logic [ADDR_WIDTH-1:0]   w_aw_idx, w_ar_idx;
    logic                    w_aw_in_range, w_ar_in_range;
    logic [NUM_REGS-1:0]     w_sel;
    logic [DATA_WIDTH-1:0]   w_rdata_mux;
    logic                    w_unused;

    // Readies are always the inverse of the hold state, so a handshake only lands in an empty hold.
    always_comb begin
        w_aw_hs       = s_axi.awvalid & r_awready;
        w_w_hs        = s_axi.wvalid & r_wready;
        w_ar_hs       = s_axi.arvalid & r_arready;
        w_commit      = r_aw_full & r_w_full & ~r_bvalid;
        w_aw_full_nxt = w_commit ? 1'b0 : (r_aw_full | w_aw_hs);
        w_w_full_nxt  = w_commit ? 1'b0 : (r_w_full | w_w_hs);
        w_rvalid_nxt  = w_ar_hs | (r_rvalid & ~s_axi.rready);
        w_aw_idx      = r_awaddr >> c_word_lsb;
        w_ar_idx      = s_axi.araddr >> c_word_lsb;
        w_aw_in_range = w_aw_idx < ADDR_WIDTH'(NUM_REGS);
        w_ar_in_range = w_ar_idx < ADDR_WIDTH'(NUM_REGS);
    end

    // Register contents are sampled before the edge, so a same-edge write is not visible here.
    always_comb begin
        w_rdata_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == ADDR_WIDTH'(i)) w_rdata_mux = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_arready  <= 1'b0;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_awready <= ~w_aw_full_nxt;
            r_wready  <= ~w_w_full_nxt;
            if (w_aw_hs) r_awaddr <= s_axi.awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axi.wdata;
                r_wstrb <= s_axi.wstrb;
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= resp_for(w_aw_in_range);
            end else if (r_bvalid && s_axi.bready) begin
                r_bvalid <= 1'b0;
            end
            r_wr_pulse <= w_commit ? w_sel : '0;

            r_rvalid  <= w_rvalid_nxt;
            r_arready <= ~w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rdata_mux;
                r_rresp <= resp_for(w_ar_in_range);
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign w_sel[i] = (w_aw_idx == ADDR_WIDTH'(i));

        axi_strb_reg #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_reg (
            .clk     (aclk),
            .rst     (areset),
            .i_we    (w_commit & w_sel[i]),
            .i_strb  (r_wstrb),
            .i_wdata (r_wdata),
            .o_q     (regs_o[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.arready = r_arready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;
    assign wr_pulse_o    = r_wr_pulse;

    // Protection attributes carry no meaning for this register block.
    assign w_unused = ^{s_axi.awprot, s_axi.arprot};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_regfile
// Description : Directed self-checking bench for axi_lite_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;
    import axi_lite_regfile_pkg::*;

    localparam int c_nregs = 16;

    logic                  aclk;
    logic                  areset;
    logic [c_nregs*32-1:0] regs_o;
    logic [c_nregs-1:0]    wr_pulse;
    logic [31:0]           exp_regs [c_nregs];
    int                    n_total;
    int                    n_bad;

    axi_lite_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (c_nregs)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_axi      (bus.slave),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < c_nregs; i++) check(tag, 64'(regs_o[i*32 +: 32]), 64'(exp_regs[i]));
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_go, w_go;
        int   guard;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        guard = 0;
        while ((bus.awvalid || bus.wvalid) && guard < 20) begin
            aw_go = bus.awvalid & bus.awready;
            w_go  = bus.wvalid & bus.wready;
            @(negedge aclk);
            if (aw_go) bus.awvalid = 1'b0;
            if (w_go)  bus.wvalid  = 1'b0;
            guard++;
        end
        if (bus.awvalid || bus.wvalid) check("wr_addr_data_timeout", 64'h0, 64'h1);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        guard = 0;
        while (!bus.bvalid && guard < 20) begin
            @(negedge aclk);
            guard++;
        end
        if (!bus.bvalid) check("wr_resp_timeout", 64'h0, 64'h1);
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ar_go;
        int   guard;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        guard = 0;
        while (bus.arvalid && guard < 20) begin
            ar_go = bus.arready;
            @(negedge aclk);
            if (ar_go) bus.arvalid = 1'b0;
            guard++;
        end
        if (bus.arvalid) check("rd_addr_timeout", 64'h0, 64'h1);
        bus.arvalid = 1'b0;
        guard = 0;
        while (!bus.rvalid && guard < 20) begin
            @(negedge aclk);
            guard++;
        end
        if (!bus.rvalid) check("rd_data_timeout", 64'h0, 64'h1);
        d    = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;

    initial begin
        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < c_nregs; i++) exp_regs[i] = 32'h0;
        areset      = 1'b1;
        bus.awaddr  = '0;  bus.awprot = '0;  bus.awvalid = 1'b0;
        bus.wdata   = '0;  bus.wstrb  = '0;  bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;  bus.arprot = '0;  bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        repeat (3) @(negedge aclk);

        // Reset values
        check("rst_awready", 64'(bus.awready), 64'h0);
        check("rst_arready", 64'(bus.arready), 64'h0);
        check("rst_bvalid",  64'(bus.bvalid),  64'h0);
        check("rst_rvalid",  64'(bus.rvalid),  64'h0);
        check("rst_rdata",   64'(bus.rdata),   64'h0);
        check("rst_pulse",   64'(wr_pulse),    64'h0);
        check_regs("rst_regs");
        areset = 1'b0;
        @(negedge aclk);
        check("rel_awready", 64'(bus.awready), 64'h1);
        check("rel_wready",  64'(bus.wready),  64'h1);
        check("rel_arready", 64'(bus.arready), 64'h1);

        // Single write, AW and W together, cycle-exact
        bus.awaddr = 32'h08; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("w1_bvalid_early", 64'(bus.bvalid),  64'h0);
        check("w1_awready_busy", 64'(bus.awready), 64'h0);
        @(negedge aclk);
        exp_regs[2] = 32'hDEADBEEF;
        check("w1_bvalid", 64'(bus.bvalid), 64'h1);
        check("w1_bresp",  64'(bus.bresp),  64'(RESP_OKAY));
        check("w1_pulse",  64'(wr_pulse),   64'h0004);
        check_regs("w1_regs");
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        check("w1_bvalid_clr", 64'(bus.bvalid), 64'h0);
        check("w1_pulse_clr",  64'(wr_pulse),   64'h0);

        // Partial strobe
        axi_write(32'h08, 32'h11223344, 4'h5, resp);
        exp_regs[2] = 32'hDE22BE44;
        check("ps_bresp", 64'(resp), 64'(RESP_OKAY));
        check_regs("ps_regs");
        axi_read(32'h08, rd, resp);
        check("ps_rdata", 64'(rd),   64'hDE22BE44);
        check("ps_rresp", 64'(resp), 64'(RESP_OKAY));
        axi_read(32'h0B, rd, resp);
        check("lowbits_rdata", 64'(rd), 64'hDE22BE44);

        // Skewed channels: W three edges ahead of AW, bready held low
        bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.wvalid = 1'b0;
        check("sk_wready_held", 64'(bus.wready), 64'h0);
        repeat (2) @(negedge aclk);
        check("sk_no_bvalid", 64'(bus.bvalid), 64'h0);
        bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        @(negedge aclk);
        exp_regs[3] = 32'hA5A5A5A5;
        check("sk_bvalid", 64'(bus.bvalid), 64'h1);
        check("sk_pulse",  64'(wr_pulse),   64'h0008);
        check_regs("sk_regs");
        bus.awaddr = 32'h10; bus.wdata = 32'h00000055; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("sk_bvalid_hold", 64'(bus.bvalid),        64'h1);
            check("sk_bresp_hold",  64'(bus.bresp),         64'(RESP_OKAY));
            check("sk_reg4_wait",   64'(regs_o[4*32 +: 32]), 64'h0);
            check("sk_awready_full", 64'(bus.awready),      64'h0);
            if (c < 2) @(negedge aclk);
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        check("sk_bvalid_clr", 64'(bus.bvalid),         64'h0);
        check("sk_no_same_edge", 64'(regs_o[4*32 +: 32]), 64'h0);
        @(negedge aclk);
        exp_regs[4] = 32'h00000055;
        check("sk2_bvalid", 64'(bus.bvalid), 64'h1);
        check("sk2_pulse",  64'(wr_pulse),   64'h0010);
        check_regs("sk2_regs");
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;

        // Out of range
        bus.awaddr = 32'h40; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge aclk);
        check("oor_bvalid", 64'(bus.bvalid), 64'h1);
        check("oor_bresp",  64'(bus.bresp),  64'(RESP_SLVERR));
        check("oor_pulse",  64'(wr_pulse),   64'h0);
        check_regs("oor_regs");
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        axi_read(32'h40, rd, resp);
        check("oor_rdata", 64'(rd),   64'h0);
        check("oor_rresp", 64'(resp), 64'(RESP_SLVERR));
        axi_read(32'h3C, rd, resp);
        check("last_rresp", 64'(resp), 64'(RESP_OKAY));

        // Same-edge read and write commit on register 1
        axi_write(32'h04, 32'h1, 4'hF, resp);
        exp_regs[1] = 32'h1;
        bus.awaddr = 32'h04; bus.wdata = 32'h2; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h04; bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        exp_regs[1] = 32'h2;
        check("se_rvalid", 64'(bus.rvalid), 64'h1);
        check("se_bvalid", 64'(bus.bvalid), 64'h1);
        check("se_rdata_old", 64'(bus.rdata), 64'h1);
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0; bus.bready = 1'b0;
        check("se_arready_back", 64'(bus.arready), 64'h1);
        axi_read(32'h04, rd, resp);
        check("se_rdata_new", 64'(rd), 64'h2);
        check_regs("se_regs");

        // Reset with AW held and read response pending
        bus.awaddr = 32'h14; bus.awvalid = 1'b1;
        bus.araddr = 32'h08; bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        check("ar_rvalid_pend", 64'(bus.rvalid),  64'h1);
        check("ar_aw_held",     64'(bus.awready), 64'h0);
        areset = 1'b1;
        @(negedge aclk);
        for (int i = 0; i < c_nregs; i++) exp_regs[i] = 32'h0;
        check("ar_rvalid", 64'(bus.rvalid),  64'h0);
        check("ar_bvalid", 64'(bus.bvalid),  64'h0);
        check("ar_awready", 64'(bus.awready), 64'h0);
        check("ar_pulse",  64'(wr_pulse),    64'h0);
        check_regs("ar_regs");
        areset = 1'b0;
        @(negedge aclk);
        check("ar_rel_awready", 64'(bus.awready), 64'h1);
        check("ar_rel_wready",  64'(bus.wready),  64'h1);
        check("ar_rel_arready", 64'(bus.arready), 64'h1);
        bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge aclk);
        bus.wvalid = 1'b0;
        repeat (2) begin
            @(negedge aclk);
            check("ar_no_spur_bvalid", 64'(bus.bvalid), 64'h0);
        end
        check_regs("ar_final_regs");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
